// File: rtl/ts_pkt_gen_if.sv
// Word-stream bundle between the TS packet generator and downstream TS checkers.
interface ts_pkt_gen_if;
  logic [31:0] ts_dout;
  logic        ts_dout_en;
  logic        pkt_done;
  logic [3:0]  cc_out;

  modport master (output ts_dout, ts_dout_en, pkt_done, cc_out);
  modport slave  (input  ts_dout, ts_dout_en, pkt_done, cc_out);
endinterface

// File: rtl/ts_pkt_gen.sv
// MPEG-TS packet source: tag prefix, header with PID/CC, 46-word byte-ramp payload, then gap.
// Optional one-shot CC skip for exercising downstream continuity checkers.
module ts_pkt_gen #(
  parameter logic [12:0] PID          = 13'h1386,
  parameter int          PREFIX_WORDS = 3,
  parameter int          GAP_CYCLES   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         err_inject,
  ts_pkt_gen_if.master ts
);

  typedef enum logic [2:0] {IDLE, PREFIX, HDR, PAYLOAD, GAP} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [5:0]  wcnt;
  logic [15:0] gcnt;
  logic [3:0]  cc_reg;
  logic [15:0] pkt_cnt;
  logic        err_pend;

  logic        gap_last;
  logic        launch;
  logic        to_hdr;
  logic [3:0]  cc_emit;
  logic [7:0]  b0;

  // State names the word currently on ts_dout; each edge computes the next word.
  always_comb begin
    gap_last = (gcnt == 16'(GAP_CYCLES - 1));
    launch   = enable && ((state == IDLE) || (state == GAP && gap_last));
    to_hdr   = (state == PREFIX && idx == 4'(PREFIX_WORDS - 1)) ||
               (launch && PREFIX_WORDS == 0);
    cc_emit  = cc_reg + {3'b000, err_pend};
    b0       = {wcnt, 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      wcnt          <= '0;
      gcnt          <= '0;
      cc_reg        <= '0;
      pkt_cnt       <= '0;
      err_pend      <= 1'b0;
      ts.ts_dout    <= '0;
      ts.ts_dout_en <= 1'b0;
      ts.pkt_done   <= 1'b0;
      ts.cc_out     <= '0;
    end else begin
      ts.pkt_done <= 1'b0;
      if (to_hdr) begin
        // A pulse landing on the header edge is kept for the following packet.
        state         <= HDR;
        wcnt          <= '0;
        ts.ts_dout_en <= 1'b1;
        ts.ts_dout    <= {8'h47, 3'b000, PID, 2'b00, 2'b01, cc_emit};
        ts.cc_out     <= cc_emit;
        cc_reg        <= cc_emit + 4'd1;
        err_pend      <= err_inject;
      end else begin
        if (err_inject) err_pend <= 1'b1;
        case (state)
          IDLE, GAP: begin
            if (launch) begin
              state         <= PREFIX;
              idx           <= '0;
              ts.ts_dout_en <= 1'b1;
              ts.ts_dout    <= {8'hB8, 8'h00, pkt_cnt};
            end else if (state == GAP) begin
              if (gap_last) state <= IDLE;
              else          gcnt  <= gcnt + 16'd1;
            end
          end
          PREFIX: begin
            idx        <= idx + 4'd1;
            ts.ts_dout <= {8'hB8, 4'h0, idx + 4'd1, pkt_cnt};
          end
          HDR, PAYLOAD: begin
            if (state == PAYLOAD && wcnt == 6'd46) begin
              state         <= GAP;
              gcnt          <= '0;
              pkt_cnt       <= pkt_cnt + 16'd1;
              ts.ts_dout_en <= 1'b0;
              ts.ts_dout    <= '0;
            end else begin
              // wcnt = payload words already sent; next word starts at byte 4*wcnt.
              state       <= PAYLOAD;
              wcnt        <= wcnt + 6'd1;
              ts.ts_dout  <= {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
              ts.pkt_done <= (wcnt == 6'd45);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ts_pkt_gen.sv
// Bench for ts_pkt_gen: default build (A) and PREFIX_WORDS=0/GAP_CYCLES=1 build (B)
// against a burst-position reference model, plus literal spot checks.
module tb_ts_pkt_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] enable_v;
  logic [1:0] err_v;

  always #5 clk = ~clk;

  ts_pkt_gen_if tsa ();
  ts_pkt_gen_if tsb ();

  ts_pkt_gen u_a (
    .clk(clk), .rst(rst), .enable(enable_v[0]), .err_inject(err_v[0]), .ts(tsa.master)
  );

  ts_pkt_gen #(.PREFIX_WORDS(0), .GAP_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .enable(enable_v[1]), .err_inject(err_v[1]), .ts(tsb.master)
  );

  logic [1:0]  en_o, done_o;
  logic [31:0] dout_o [2];
  logic [3:0]  cc_o [2];
  assign en_o[0] = tsa.ts_dout_en;  assign en_o[1] = tsb.ts_dout_en;
  assign done_o[0] = tsa.pkt_done;  assign done_o[1] = tsb.pkt_done;
  assign dout_o[0] = tsa.ts_dout;   assign dout_o[1] = tsb.ts_dout;
  assign cc_o[0] = tsa.cc_out;      assign cc_o[1] = tsb.cc_out;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic int pw(int i); return (i == 0) ? 3 : 0; endfunction
  function automatic int gc(int i); return (i == 0) ? 4 : 1; endfunction

  // Expected word at burst position pos: prefix tags, header, then byte ramp.
  function automatic logic [31:0] exp_word(int p, int pos, int cc, int pk);
    int b;
    if (pos < p)  return {8'hB8, 4'h0, 4'(pos), 16'(pk)};
    if (pos == p) return {8'h47, 3'b000, 13'h1386, 4'b0001, 4'(cc)};
    b = 4 * (pos - p - 1);
    return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
  endfunction

  // Reference model: burst position, remaining gap cycles, CC, pending skip.
  int m_busy [2], m_pos [2], m_gap [2], m_cc [2], m_lcc [2], m_pend [2], m_pkt [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_pos[i] = 0; m_gap[i] = 0; m_cc[i] = 0;
      m_lcc[i] = 0; m_pend[i] = 0; m_pkt[i] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_busy[i] = 0; m_pos[i] = 0; m_gap[i] = 0; m_cc[i] = 0;
          m_lcc[i] = 0; m_pend[i] = 0; m_pkt[i] = 0;
        end else begin
          if (m_busy[i] != 0) begin
            if (m_pos[i] == pw(i) + 46) begin
              m_busy[i] = 0; m_gap[i] = gc(i); m_pkt[i] = (m_pkt[i] + 1) % 65536;
            end else m_pos[i]++;
          end else if (m_gap[i] > 1) m_gap[i]--;
          else begin
            m_gap[i] = 0;
            if (enable_v[i]) begin m_busy[i] = 1; m_pos[i] = 0; end
          end
          if (m_busy[i] != 0 && m_pos[i] == pw(i)) begin
            m_lcc[i]  = (m_cc[i] + m_pend[i]) % 16;
            m_cc[i]   = (m_cc[i] + 1 + m_pend[i]) % 16;
            m_pend[i] = err_v[i] ? 1 : 0;
          end else if (err_v[i]) m_pend[i] = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("ts_dout_en", i, {31'b0, en_o[i]}, {31'b0, m_busy[i] != 0});
      if (m_busy[i] != 0)
        chk("ts_dout", i, dout_o[i], exp_word(pw(i), m_pos[i], m_lcc[i], m_pkt[i]));
      chk("pkt_done", i, {31'b0, done_o[i]}, {31'b0, m_busy[i] != 0 && m_pos[i] == pw(i) + 46});
      chk("cc_out", i, {28'b0, cc_o[i]}, 32'(m_lcc[i]));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Burst observers for literal checks.
  int qa_len[$], qa_hdr[$], qa_w0[$], qa_start[$];
  int qb_len[$], qb_w0[$], qb_w1[$], qb_w46[$], qb_start[$];
  int ra = 0, rb = 0, done_a = 0;

  initial forever begin
    @(negedge clk);
    if (rst) ra = 0;
    else if (tsa.ts_dout_en) begin
      if (ra == 0) begin qa_start.push_back(cyc); qa_w0.push_back(tsa.ts_dout); end
      if (ra == 3) qa_hdr.push_back(tsa.ts_dout);
      ra++;
    end else if (ra > 0) begin qa_len.push_back(ra); ra = 0; end
    if (tsa.pkt_done) done_a++;
  end

  initial forever begin
    @(negedge clk);
    if (rst) rb = 0;
    else if (tsb.ts_dout_en) begin
      if (rb == 0) begin qb_start.push_back(cyc); qb_w0.push_back(tsb.ts_dout); end
      if (rb == 1)  qb_w1.push_back(tsb.ts_dout);
      if (rb == 46) qb_w46.push_back(tsb.ts_dout);
      rb++;
    end else if (rb > 0) begin qb_len.push_back(rb); rb = 0; end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_hdr(int n, int budget);
    int t = 0;
    while (qa_hdr.size() < n && t < budget) begin @(posedge clk); #1; t++; end
    checks++;
    if (qa_hdr.size() < n) begin
      errors++;
      $display("FAIL wait_hdr got %0d headers, needed %0d", qa_hdr.size(), n);
    end
  endtask

  task automatic clear_a();
    qa_len.delete(); qa_hdr.delete(); qa_w0.delete(); qa_start.delete();
  endtask

  initial begin
    int n0, d0, busy_cnt;
    logic [3:0] nxt;
    rst = 1'b1; enable_v = 2'b00; err_v = 2'b00;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_dout", i, dout_o[i], 32'h0);
      chk("rst_en", i, {31'b0, en_o[i]}, 32'h0);
      chk("rst_done", i, {31'b0, done_o[i]}, 32'h0);
      chk("rst_cc", i, {28'b0, cc_o[i]}, 32'h0);
    end
    rst = 1'b0; enable_v = 2'b11;

    // Back-to-back packets: framing, headers, CC wrap.
    wait_hdr(18, 18 * 54 + 100);
    for (int k = 0; k < 3; k++) chk("burst_len", 0, qa_len[k], 50);
    for (int k = 0; k < 2; k++) chk("period", 0, qa_start[k + 1] - qa_start[k], 54);
    chk("hdr0", 0, qa_hdr[0], 32'h47138610);
    chk("hdr1", 0, qa_hdr[1], 32'h47138611);
    chk("hdr2", 0, qa_hdr[2], 32'h47138612);
    chk("prefix0_pkt2", 0, qa_w0[2], 32'hB8000002);
    for (int k = 0; k < 17; k++) chk("cc_seq", 0, qa_hdr[k] & 32'hF, 32'(k % 16));
    chk("b_first_is_hdr", 1, qb_w0[0], 32'h47138610);
    chk("b_word1", 1, qb_w1[0], 32'h00010203);
    chk("b_word46", 1, qb_w46[0], 32'hB4B5B6B7);
    chk("b_len", 1, qb_len[0], 47);
    chk("b_period", 1, qb_start[1] - qb_start[0], 48);

    // CC skip injected during packet 2's payload.
    rst = 1'b1; tick(2); clear_a(); rst = 1'b0;
    wait_hdr(3, 300);
    tick(10);
    err_v[0] = 1'b1; tick(1); err_v[0] = 1'b0;
    wait_hdr(5, 300);
    chk("err_hdr3_cc", 0, qa_hdr[3] & 32'hF, 32'd4);
    chk("err_hdr4_cc", 0, qa_hdr[4] & 32'hF, 32'd5);
    for (int k = 1; k < 5; k++) begin
      nxt = 4'(qa_hdr[k - 1]) + 4'd1;
      chk("cc_checker_flag", 0, {31'b0, 4'(qa_hdr[k]) != nxt}, {31'b0, k == 3});
    end

    // Enable dropped at payload word 10: burst completes, then idle.
    wait_hdr(qa_hdr.size() + 1, 200);
    tick(9);
    enable_v[0] = 1'b0;
    n0 = qa_len.size(); d0 = done_a;
    tick(50);
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin tick(1); if (tsa.ts_dout_en) busy_cnt++; end
    chk("drop_bursts", 0, qa_len.size(), n0 + 1);
    chk("drop_len", 0, qa_len[$], 50);
    chk("drop_done_once", 0, done_a, d0 + 1);
    chk("drop_stays_idle", 0, busy_cnt, 0);

    // Reset at payload word 20, then restart from CC 0 / pkt_cnt 0.
    enable_v[0] = 1'b1;
    wait_hdr(qa_hdr.size() + 1, 200);
    tick(19);
    rst = 1'b1; #1;
    chk("midrst_en", 0, {31'b0, tsa.ts_dout_en}, 32'h0);
    chk("midrst_dout", 0, tsa.ts_dout, 32'h0);
    chk("midrst_cc", 0, {28'b0, tsa.cc_out}, 32'h0);
    tick(2); clear_a(); rst = 1'b0;
    wait_hdr(1, 100);
    chk("rst_hdr_cc0", 0, qa_hdr[0], 32'h47138610);
    chk("rst_pkt_cnt0", 0, qa_w0[0], 32'hB8000000);

    // Random enable/err_inject traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 99) < 2) enable_v[i] = ~enable_v[i];
        err_v[i] = ($urandom_range(0, 99) < 4);
      end
    end
    err_v = 2'b00; enable_v = 2'b00;
    tick(120);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
